symbol_store_unit: RTL and testbench

Write-side counterpart of the symbol memory. It takes a stream of symbols through a valid/ready handshake and writes them to consecutive addresses in an internal RAM, starting at address 0. It tracks the symbol count and signals completion. A registered read port, with the same timing as the symbol ROM, lets the downstream sort stage read the stored symbols.

---
 rtl/symbol_store_unit.sv | 137 +++++++++++++
 tb/tb_symbol_store_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/symbol_store_unit.sv
// symbol_store_unit: accepts a valid/ready symbol stream and writes it to
// consecutive RAM addresses from 0. It tracks the symbol count, flags
// completion and overflow, and offers a registered read port for the sort stage.
// Optional build macro: SYMBOL_CHECKSUM_EN adds a running modulo-2^DATA_WIDTH
// checksum output covering the current load.
module symbol_store_unit #(
  parameter int DATA_WIDTH    = 16,
  parameter int TOTAL_SYMBOLS = 10,
  parameter int ADDR_WIDTH    = 4
) (
  input  logic                  wClk,
  input  logic                  wRst,
  input  logic                  start,
  input  logic                  wEn,
  input  logic [DATA_WIDTH-1:0] wData,
  input  logic                  wLast,
  output logic                  wReady,
  input  logic                  rEn,
  input  logic [ADDR_WIDTH-1:0] rAddr,
  output logic [DATA_WIDTH-1:0] rData,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  done,
  output logic                  overflow
`ifdef SYMBOL_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  localparam logic [ADDR_WIDTH:0] TOTAL = (ADDR_WIDTH+1)'(TOTAL_SYMBOLS);

  state_t                state;
  state_t                state_next;
  logic [DATA_WIDTH-1:0] mem [TOTAL_SYMBOLS];
  logic [ADDR_WIDTH:0]   count_inc;
  logic                  accept;
  logic                  ovf_hit;

  assign count_inc = count + 1'b1;
  assign wReady    = (state == LOAD);
  assign done      = (state == DONE);
  assign full      = (count == TOTAL);

  // Next-state logic plus the accept/overflow strobes for the datapath
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    ovf_hit    = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = LOAD;
        end else if (wEn) begin
          ovf_hit = 1'b1;
        end
      end
      LOAD: begin
        // A start in LOAD restarts the load and drops any simultaneous write
        if (!start && wEn) begin
          accept = 1'b1;
          if (wLast || (count_inc == TOTAL)) begin
            state_next = DONE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge wClk) begin
    if (wRst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Symbol count and sticky overflow; start clears both in every state
  always_ff @(posedge wClk) begin
    if (wRst) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (start) begin
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        count <= count_inc;
      end
      if (ovf_hit) begin
        overflow <= 1'b1;
      end
    end
  end

  // RAM write port; contents survive reset
  always_ff @(posedge wClk) begin
    if (!wRst && accept) begin
      mem[count[ADDR_WIDTH-1:0]] <= wData;
    end
  end

  // Registered read port; same-address write in this cycle returns old data
  always_ff @(posedge wClk) begin
    if (wRst) begin
      rData <= '0;
    end else if (rEn) begin
      if ({1'b0, rAddr} < TOTAL) begin
        rData <= mem[rAddr];
      end else begin
        rData <= '0;
      end
    end
  end

`ifdef SYMBOL_CHECKSUM_EN
  // Running checksum of accepted symbols, updated with the RAM write
  always_ff @(posedge wClk) begin
    if (wRst || start) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= checksum + wData;
    end
  end
`else
  // Checksum port and logic are absent in this build
`endif

endmodule

// File: tb/tb_symbol_store_unit.sv
// Testbench for symbol_store_unit: directed steps from the test plan followed
// by random traffic, all checked against a behavioural model of the store.
module tb_symbol_store_unit;
  localparam int DW = 16;
  localparam int N  = 10;
  localparam int AW = 4;

  logic          wClk = 1'b0;
  logic          wRst = 1'b1;
  logic          start = 1'b0;
  logic          wEn = 1'b0;
  logic [DW-1:0] wData = '0;
  logic          wLast = 1'b0;
  logic          wReady;
  logic          rEn = 1'b0;
  logic [AW-1:0] rAddr = '0;
  logic [DW-1:0] rData;
  logic [AW:0]   count;
  logic          full;
  logic          done;
  logic          overflow;
`ifdef SYMBOL_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  int total = 0;
  int bad   = 0;

  // Behavioural model
  logic [DW-1:0] m_mem [N];
  bit            m_load;
  bit            m_fin;
  bit            m_ovf;
  int            m_cnt;
  logic [DW-1:0] m_rd;
  logic [DW-1:0] m_cs;

  symbol_store_unit #(
    .DATA_WIDTH   (DW),
    .TOTAL_SYMBOLS(N),
    .ADDR_WIDTH   (AW)
  ) dut (
    .wClk    (wClk),
    .wRst    (wRst),
    .start   (start),
    .wEn     (wEn),
    .wData   (wData),
    .wLast   (wLast),
    .wReady  (wReady),
    .rEn     (rEn),
    .rAddr   (rAddr),
    .rData   (rData),
    .count   (count),
    .full    (full),
    .done    (done),
    .overflow(overflow)
`ifdef SYMBOL_CHECKSUM_EN
    ,
    .checksum(checksum)
`endif
  );

  always #5 wClk = ~wClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, advance the model, compare all outputs
  task automatic step(input bit r, input bit s, input bit we, input logic [DW-1:0] wd,
                      input bit wl, input bit re, input logic [AW-1:0] ra);
    @(negedge wClk);
    wRst = r; start = s; wEn = we; wData = wd; wLast = wl; rEn = re; rAddr = ra;
    @(posedge wClk);
    if (r) begin
      m_load = 0; m_fin = 0; m_cnt = 0; m_ovf = 0; m_rd = '0; m_cs = '0;
    end else begin
      if (re) m_rd = (int'(ra) < N) ? m_mem[ra] : '0;
      if (s) begin
        m_load = 1; m_fin = 0; m_cnt = 0; m_ovf = 0; m_cs = '0;
      end else if (we && m_load) begin
        m_mem[m_cnt] = wd;
        m_cnt++;
        m_cs += wd;
        if (wl || m_cnt == N) begin
          m_load = 0;
          m_fin  = 1;
        end
      end else if (we) begin
        m_ovf = 1;
      end
    end
    #1;
    chk("wReady", 32'(wReady), 32'(m_load));
    chk("done", 32'(done), 32'(m_fin));
    chk("full", 32'(full), 32'(m_cnt == N));
    chk("count", 32'(count), 32'(m_cnt));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("rData", 32'(rData), 32'(m_rd));
`ifdef SYMBOL_CHECKSUM_EN
    chk("checksum", 32'(checksum), 32'(m_cs));
`endif
  endtask

  initial begin
    int rc;
    // Reset
    step(1, 0, 0, '0, 0, 0, '0);
    step(1, 0, 0, '0, 0, 0, '0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(wReady), 32'd0);

    // Full load of 10 symbols with wEn held high
    step(0, 1, 0, '0, 0, 0, '0);
    rc = int'(wReady);
    for (int i = 1; i <= N; i++) begin
      step(0, 0, 1, DW'(i), 0, 0, '0);
      rc += int'(wReady);
    end
    chk("ready_cycles", 32'(rc), 32'd10);
    chk("done10", 32'(done), 32'd1);
    chk("full10", 32'(full), 32'd1);
    chk("count10", 32'(count), 32'd10);
    for (int i = 0; i < N; i++) begin
      step(0, 0, 0, '0, 0, 1, AW'(i));
      chk("read_full", 32'(rData), 32'(i + 1));
    end

    // Short load terminated by wLast
    step(0, 1, 0, '0, 0, 0, '0);
    step(0, 0, 1, 16'h00AA, 0, 0, '0);
    step(0, 0, 1, 16'h00BB, 0, 0, '0);
    step(0, 0, 1, 16'h00CC, 1, 0, '0);
    chk("done3", 32'(done), 32'd1);
    chk("count3", 32'(count), 32'd3);
    chk("full3", 32'(full), 32'd0);
    step(0, 0, 0, '0, 0, 1, 4'd2);
    chk("read_cc", 32'(rData), 32'h00CC);

    // Write while DONE raises overflow, start clears it
    step(0, 0, 1, 16'hFFFF, 0, 1, 4'd0);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd3);
    chk("ovf_read0", 32'(rData), 32'h00AA);
    step(0, 1, 0, '0, 0, 0, '0);
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Reset in the middle of a load
    for (int i = 1; i <= 4; i++) step(0, 0, 1, DW'(16'h0100 + i), 0, 0, '0);
    step(1, 0, 1, 16'h0EEE, 0, 0, '0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_ready", 32'(wReady), 32'd0);
    step(0, 0, 0, '0, 0, 1, 4'd3);
    chk("read_after_rst", 32'(rData), 32'h0104);

    // Out-of-range read, then hold with rEn low
    step(0, 0, 0, '0, 0, 1, 4'd12);
    chk("read_oob", 32'(rData), 32'h0000);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, DW'($urandom), 0, 0, AW'(i));
      chk("read_hold", 32'(rData), 32'h0000);
    end

`ifdef SYMBOL_CHECKSUM_EN
    step(0, 1, 0, '0, 0, 0, '0);
    step(0, 0, 1, 16'h8000, 0, 0, '0);
    step(0, 0, 1, 16'h8000, 0, 0, '0);
    step(0, 0, 1, 16'h0005, 1, 0, '0);
    chk("cs_wrap", 32'(checksum), 32'h0005);
    step(0, 1, 0, '0, 0, 0, '0);
    chk("cs_clr", 32'(checksum), 32'h0000);
`endif

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 59) == 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 5) == 0,
           $urandom_range(0, 1) == 1, AW'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
